inst_trace_buffer: RTL and testbench
====================================

# inst_trace_buffer

Parametrised instruction-trace recorder for the RISC-V core. It captures every retired instruction (PC and raw encoding) into a circular buffer and freezes on a programmable trigger after a fixed post-trigger count. After freezing, it streams the captured window out oldest-first over a valid/ready port. It sits beside the core's retire path as a non-intrusive debug observer and never back-pressures the core.

## Interface
- DEPTH, 16, trace entries; power of two, ≥ 4
- PC_WIDTH, 32, width of recorded PC
- INST_WIDTH, 32, width of recorded instruction
- POST_TRIG, 2, entries recorded after the trigger entry; legal range 0..DEPTH-1
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- arm  in  1  pulse: clear buffer and counters, enter ARMED
- ret_valid  in  1  one instruction retires this cycle
- ret_pc  in  PC_WIDTH  retiring PC
- ret_inst  in  INST_WIDTH  retiring instruction
- trig_mode  in  2  00 manual only, 01 PC match, 10 opcode match, 11 PC or opcode
- trig_pc  in  PC_WIDTH  PC compare value
- trig_opcode  in  7  compared against ret_inst[6:0]
- force_trig  in  1  manual trigger, honoured in ARMED regardless of trig_mode
- state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
- fill  out  $clog2(DEPTH)+1  valid entries held
- ret_cnt  out  32  retirements seen while ARMED or POST; saturates at 0xFFFFFFFF
- out_valid  out  1  out_pc/out_inst hold a valid entry
- out_ready  in  1  consumer accepts entry
- out_pc  out  PC_WIDTH  drained PC
- out_inst  out  INST_WIDTH  drained instruction
- out_last  out  1  current entry is the final entry of the window

## Operation
- Reset: state=IDLE; wr_ptr, fill, post counter, ret_cnt, out_valid, out_pc, out_inst, out_last all 0.
- arm has priority over every other input in every state. The next state is ARMED, with wr_ptr, fill, and ret_cnt cleared and out_valid=0. A ret_valid in the same cycle as arm is not recorded.
- IDLE: ret_valid is ignored.
- ARMED: each ret_valid writes {ret_pc, ret_inst} at wr_ptr. wr_ptr increments mod DEPTH; fill increments and saturates at DEPTH, with the oldest entry overwritten.
- Trigger in ARMED:
  - A hit is (mode bit0 & ret_valid & ret_pc==trig_pc) | (mode bit1 & ret_valid & ret_inst[6:0]==trig_opcode) | force_trig.
  - A triggering retire is itself written. Then post counter ← POST_TRIG.
  - If POST_TRIG==0, go to FROZEN; otherwise go to POST.
  - A force_trig without ret_valid writes nothing.
- POST: each ret_valid writes and decrements the counter. The write that brings the counter to 0 moves the block to FROZEN. Triggers are ignored.
- FROZEN:
  - Recording stops. The read pointer starts at (wr_ptr − fill) mod DEPTH.
  - Each out_valid & out_ready transfer advances the read pointer and decrements fill.
  - out_last=1 when fill==1.
  - The transfer with out_last moves the block to IDLE, with out_valid=0 the next cycle.
  - If FROZEN is entered with fill==0, the next state is IDLE and out_valid is never asserted.
- ret_cnt increments on ret_valid only in ARMED and POST.

## Timing
- Capture: an entry written at edge N is counted in fill after edge N.
- Freeze: state=FROZEN after the edge that performs the final write, or after the trigger edge when POST_TRIG==0.
- Drain start: out_valid rises one cycle after state becomes FROZEN. out_pc/out_inst are registered.
- Stability: while out_valid & !out_ready, out_pc, out_inst and out_last hold stable.
- Throughput: one entry per cycle with out_ready held high; no bubbles between entries.
- Clear: an arm in FROZEN mid-drain drops out_valid on the next cycle; the remaining entries are discarded.
- Reset: asserting rst_n low mid-operation returns all outputs to their reset values immediately.

## Test plan
- Reset: hold rst_n low with random inputs -> state=0, fill=0, ret_cnt=0, out_valid=0, out_pc=out_inst=0.
- PC trigger:
  - Setup: DEPTH=8, POST_TRIG=2, trig_mode=01, trig_pc=0x40. Arm, then retire PCs 0x00,0x04,… every cycle.
  - Expected: FROZEN after PC 0x48; ret_cnt=19; fill=8.
  - Drain yields PCs 0x2C..0x48 in order, out_last only on 0x48, then state=IDLE.
- Opcode trigger, partial fill:
  - Setup: trig_mode=10, trig_opcode=0x63. Retire 2 non-branches, then a branch (0x63), then 2 more.
  - Expected: fill=5; drain gives those 5 in retire order.
- Backpressure: during drain, toggle out_ready every cycle -> each entry is held stable while not ready; no loss or duplication; 8 transfers total.
- Arm mid-drain: after 3 of 8 transfers, pulse arm together with ret_valid -> next cycle out_valid=0, fill=0, state=ARMED; that retire is not recorded.
- Manual trigger: with POST_TRIG=2, force_trig with ret_valid=0 -> state=POST, fill unchanged. Stays POST with no retires; exactly 2 further retires -> FROZEN.

Source files
------------

// File: rtl/inst_trace_buffer.sv
// Instruction-trace recorder: captures retired {pc, inst} into a circular buffer,
// freezes a programmable number of entries after a trigger, then drains oldest-first.
module inst_trace_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned POST_TRIG  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic                      ret_valid,
  input  logic [PC_WIDTH-1:0]       ret_pc,
  input  logic [INST_WIDTH-1:0]     ret_inst,
  input  logic [1:0]                trig_mode,
  input  logic [PC_WIDTH-1:0]       trig_pc,
  input  logic [6:0]                trig_opcode,
  input  logic                      force_trig,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [31:0]               ret_cnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [INST_WIDTH-1:0]     out_inst,
  output logic                      out_last
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   start_ptr;
  logic [PTR_W-1:0]   post_cnt;

  logic               pc_hit;
  logic               op_hit;
  logic               trig_hit;
  logic               xfer;
  logic               wr_en;
  logic               cnt_en;
  logic               post_load;
  logic               post_dec;
  logic               drain_start;
  logic               drain_adv;

  assign state     = state_q;
  assign pc_hit    = trig_mode[0] & ret_valid & (ret_pc == trig_pc);
  assign op_hit    = trig_mode[1] & ret_valid & (ret_inst[6:0] == trig_opcode);
  assign trig_hit  = pc_hit | op_hit | force_trig;
  assign xfer      = out_valid & out_ready;
  // Oldest entry of the window; a full buffer wraps back to wr_ptr
  assign start_ptr = wr_ptr - PTR_W'(fill);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; arm overrides everything
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    cnt_en      = 1'b0;
    post_load   = 1'b0;
    post_dec    = 1'b0;
    drain_start = 1'b0;
    drain_adv   = 1'b0;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          wr_en  = ret_valid;
          cnt_en = ret_valid;
          if (trig_hit) begin
            post_load = 1'b1;
            state_d   = (POST_TRIG == 0) ? S_FROZEN : S_POST;
          end
        end
        S_POST: begin
          wr_en  = ret_valid;
          cnt_en = ret_valid;
          if (ret_valid) begin
            post_dec = 1'b1;
            if (post_cnt == PTR_W'(1)) begin
              state_d = S_FROZEN;
            end
          end
        end
        S_FROZEN: begin
          if (!out_valid) begin
            if (fill == FILL_W'(0)) begin
              state_d = S_IDLE;
            end else begin
              drain_start = 1'b1;
            end
          end else if (xfer) begin
            drain_adv = 1'b1;
            if (out_last) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Trace storage; contents need no reset since fill qualifies them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{pc: ret_pc, inst: ret_inst};
    end
  end

  // Pointers, counters and the registered drain stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      ret_cnt   <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_last  <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      ret_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (fill != FILL_W'(DEPTH)) begin
          fill <= fill + FILL_W'(1);
        end
      end

      if (cnt_en && (ret_cnt != 32'hFFFF_FFFF)) begin
        ret_cnt <= ret_cnt + 32'd1;
      end

      if (post_load) begin
        post_cnt <= PTR_W'(POST_TRIG);
      end else if (post_dec) begin
        post_cnt <= post_cnt - PTR_W'(1);
      end

      if (drain_start) begin
        out_valid <= 1'b1;
        out_pc    <= mem[start_ptr].pc;
        out_inst  <= mem[start_ptr].inst;
        out_last  <= (fill == FILL_W'(1));
        rd_ptr    <= start_ptr + PTR_W'(1);
      end else if (drain_adv) begin
        fill <= fill - FILL_W'(1);
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          // Back-to-back reload keeps the stream bubble-free
          out_pc   <= mem[rd_ptr].pc;
          out_inst <= mem[rd_ptr].inst;
          out_last <= (fill == FILL_W'(2));
          rd_ptr   <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Scoreboard bench for inst_trace_buffer: directed capture scenarios push expected
// drain entries; a negedge monitor pops and compares each accepted transfer.
module tb_inst_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned POST  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          ret_valid = 1'b0;
  logic [PW-1:0] ret_pc = '0;
  logic [IW-1:0] ret_inst = '0;
  logic [1:0]    trig_mode = '0;
  logic [PW-1:0] trig_pc = '0;
  logic [6:0]    trig_opcode = '0;
  logic          force_trig = 1'b0;
  logic [1:0]    state;
  logic [$clog2(DEPTH):0] fill;
  logic [31:0]   ret_cnt;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic          out_last;

  inst_trace_buffer #(
    .DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW), .POST_TRIG(POST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_inst(ret_inst), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .trig_opcode(trig_opcode), .force_trig(force_trig),
    .state(state), .fill(fill), .ret_cnt(ret_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
    logic          last;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            passed = 0;
  int            xfers = 0;
  logic          hold_pend = 1'b0;
  logic [PW-1:0] h_pc;
  logic [IW-1:0] h_inst;
  logic          h_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: transfers happen at the next posedge when valid & ready here
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_stable", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, h_pc});
        chk("hold_inst_last", {31'd0, out_last, out_inst}, {31'd0, h_last, h_inst});
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL drain_extra: got pc 0x%0h expected no entry", out_pc);
        end else begin
          mon_e = q.pop_front();
          chk("drain_pc", 64'(out_pc), 64'(mon_e.pc));
          chk("drain_inst", 64'(out_inst), 64'(mon_e.inst));
          chk("drain_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      hold_pend = out_valid && !out_ready && !arm;
      h_pc      = out_pc;
      h_inst    = out_inst;
      h_last    = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] alu(input logic [PW-1:0] pc);
    return {pc[24:0], 7'h13};
  endfunction

  task automatic retire(input logic [PW-1:0] pc, input logic [IW-1:0] inst);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = inst;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push_win(input logic [PW-1:0] base, input int n);
    logic [PW-1:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = base + PW'(4 * i);
      q.push_back('{pc: pc, inst: alu(pc), last: (i == n - 1)});
    end
  endtask

  // Drain until the block returns to IDLE, bounded by a cycle budget
  task automatic drain(input int n, input bit toggle, input string name);
    int  x0;
    int  vcyc;
    int  cyc;
    bit  done;
    x0 = xfers; vcyc = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      tick();
      cyc++;
      if (out_valid) vcyc++;
      if (state == 2'd0 && !out_valid) done = 1'b1;
    end
    out_ready = 1'b0;
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_xfers"}, 64'(xfers - x0), 64'(n));
    chk({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({name, "_fill_zero"}, 64'(fill), 64'd0);
    if (!toggle) chk({name, "_no_bubbles"}, 64'(vcyc), 64'(n));
  endtask

  initial begin
    int x0;

    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      arm = 1'($urandom); ret_valid = 1'($urandom); ret_pc = $urandom;
      ret_inst = $urandom; trig_mode = 2'($urandom); force_trig = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_ret_cnt", 64'(ret_cnt), 64'd0);
    chk("rst_out", {31'd0, out_valid, out_last, out_pc[30:0]}, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    arm = 0; ret_valid = 0; force_trig = 0; out_ready = 0; trig_mode = 0;
    rst_n = 1'b1;
    tick();
    chk("idle_ignores_retire_pre", 64'(state), 64'd0);
    retire(32'h1234, 32'h13);
    chk("idle_ignores_retire", {fill, ret_cnt}, 64'd0);

    // PC trigger, buffer wraps
    trig_mode = 2'b01; trig_pc = 32'h40;
    do_arm();
    chk("arm_state", 64'(state), 64'd1);
    for (int i = 0; i < 19; i++) begin
      retire(PW'(4 * i), alu(PW'(4 * i)));
      if (i == 16) chk("pc_trig_post", 64'(state), 64'd2);
    end
    chk("pc_trig_frozen", 64'(state), 64'd3);
    chk("pc_trig_ret_cnt", 64'(ret_cnt), 64'd19);
    chk("pc_trig_fill", 64'(fill), 64'd8);
    chk("pc_trig_valid_late", 64'(out_valid), 64'd0);
    push_win(32'h2C, 8);
    drain(8, 1'b0, "pc_trig");
    chk("pc_trig_idle_cnt", 64'(ret_cnt), 64'd19);

    // Opcode trigger, partial fill; PC compare is masked by mode
    trig_mode = 2'b10; trig_opcode = 7'h63; trig_pc = 32'h100;
    do_arm();
    retire(32'h100, alu(32'h100));
    retire(32'h104, alu(32'h104));
    retire(32'h108, 32'h0020_8463);
    chk("op_trig_post", 64'(state), 64'd2);
    retire(32'h10C, alu(32'h10C));
    retire(32'h110, alu(32'h110));
    chk("op_trig_frozen", 64'(state), 64'd3);
    chk("op_trig_fill", 64'(fill), 64'd5);
    chk("op_trig_ret_cnt", 64'(ret_cnt), 64'd5);
    q.push_back('{pc: 32'h100, inst: alu(32'h100), last: 1'b0});
    q.push_back('{pc: 32'h104, inst: alu(32'h104), last: 1'b0});
    q.push_back('{pc: 32'h108, inst: 32'h0020_8463, last: 1'b0});
    q.push_back('{pc: 32'h10C, inst: alu(32'h10C), last: 1'b0});
    q.push_back('{pc: 32'h110, inst: alu(32'h110), last: 1'b1});
    drain(5, 1'b0, "op_trig");

    // Backpressure: out_ready toggles every cycle
    trig_mode = 2'b01; trig_pc = 32'h21C;
    do_arm();
    for (int i = 0; i < 10; i++) retire(32'h200 + PW'(4 * i), alu(32'h200 + PW'(4 * i)));
    chk("bp_frozen", {state, fill}, {2'd3, 4'd8});
    push_win(32'h208, 8);
    drain(8, 1'b1, "bp");

    // Arm mid-drain discards the rest; the arming retire is not recorded
    trig_pc = 32'h31C;
    do_arm();
    for (int i = 0; i < 10; i++) retire(32'h300 + PW'(4 * i), alu(32'h300 + PW'(4 * i)));
    push_win(32'h308, 8);
    tick();
    chk("mid_valid_up", 64'(out_valid), 64'd1);
    x0 = xfers;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("mid_three_xfers", 64'(xfers - x0), 64'd3);
    q.delete();
    arm = 1'b1; ret_valid = 1'b1; ret_pc = 32'hDEAD0; ret_inst = alu(32'hDEAD0);
    tick();
    arm = 1'b0; ret_valid = 1'b0;
    chk("mid_arm_valid", 64'(out_valid), 64'd0);
    chk("mid_arm_fill", 64'(fill), 64'd0);
    chk("mid_arm_state", 64'(state), 64'd1);
    chk("mid_arm_ret_cnt", 64'(ret_cnt), 64'd0);

    // Manual trigger without a retire, then exactly POST retires
    trig_mode = 2'b00;
    retire(32'h400, alu(32'h400));
    retire(32'h404, alu(32'h404));
    retire(32'h408, alu(32'h408));
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("man_post", 64'(state), 64'd2);
    chk("man_fill", 64'(fill), 64'd3);
    repeat (3) tick();
    chk("man_stays_post", 64'(state), 64'd2);
    retire(32'h40C, alu(32'h40C));
    chk("man_one_left", 64'(state), 64'd2);
    retire(32'h410, alu(32'h410));
    chk("man_frozen", {state, fill}, {2'd3, 4'd5});
    chk("man_ret_cnt", 64'(ret_cnt), 64'd5);
    push_win(32'h400, 5);
    drain(5, 1'b0, "manual");

    // Asynchronous reset mid-capture
    trig_mode = 2'b00;
    do_arm();
    retire(32'h500, alu(32'h500));
    retire(32'h504, alu(32'h504));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {state, fill, ret_cnt[3:0]}, 64'd0);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
